hs_int_add_responder: RTL and testbench
=======================================

// Module: hs_int_add_responder
// PURPOSE
//   Responder end of the stb/ack add handshake the block accumulators initiate.
//   Captures two W-bit integer operands on input_stb, adds them after a programmable latency,
//   and holds output_z with output_z_stb high until the initiator acknowledges.
//   Serves as the per-element adder lane behind the 2x2 integer accumulator.
// PARAMETERS
//   W    8  operand/result width, bits (two's complement when SAT=1)
//   LAT  2  extra compute cycles between capture and result, 0..15
//   SAT  0  0: wrap modulo 2^W; 1: signed saturate to [-2^(W-1), 2^(W-1)-1]
// PORTS
//   clk           in   1  clock, all logic on rising edge
//   reset         in   1  synchronous, active-high reset
//   input_a       in   W  operand A, sampled only on the capture edge
//   input_b       in   W  operand B, sampled only on the capture edge
//   input_stb     in   1  initiator has operands valid (level, may stay high)
//   input_ack     out  1  one-cycle pulse: operands captured
//   output_z      out  W  sum, stable while output_z_stb=1
//   output_z_stb  out  1  result valid, held until acknowledged
//   output_z_ack  in   1  initiator has taken the result
//   overflow      out  1  signed overflow of the last add, valid with output_z_stb
// BEHAVIOUR
//   Reset (reset=1 at posedge): state<=IDLE; all outputs 0; internal counter 0.
//     Reset overrides everything, including mid-COMPUTE and OUT; any in-flight result is discarded.
//   States: IDLE -> COMPUTE -> OUT -> IDLE.
//   IDLE: input_stb=1 at edge E0 -> capture a,b; input_ack=1 for the cycle after E0; cnt<=LAT; go COMPUTE.
//     input_stb=0 -> stay IDLE; output_z_ack ignored.
//   COMPUTE: cnt>0 -> cnt<=cnt-1; cnt==0 -> register sum/overflow, output_z_stb<=1, go OUT.
//     output_z_stb rises at edge E0+LAT+1 (LAT=0 -> 1 cycle after capture).
//     input_stb and output_z_ack are ignored.
//   OUT: output_z and overflow are held stable.
//     output_z_ack=1 at an edge -> output_z_stb<=0, go IDLE; output_z keeps its value.
//     output_z_ack is honoured only in OUT. An ack held high from an earlier state is
//     accepted at the first edge in OUT, so stb is high for exactly 1 cycle.
//   Back-to-back: input_stb still high in IDLE after OUT -> new capture next edge.
//     Minimum period per add = LAT+3 cycles.
//   Arithmetic: s = a+b computed at W+1 bits.
//     overflow = (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1]).
//     SAT=0: output_z = s[W-1:0].
//     SAT=1 with overflow: output_z = a[W-1] ? {1'b1,{W-1{1'b0}}} : {1'b0,{W-1{1'b1}}}.
//   Operands changing after capture have no effect on the pending result.
// TESTING
//   W=8,LAT=2,SAT=0: a=8'h12,b=8'h34, stb 1 cycle -> input_ack pulse; output_z_stb at E0+3; z=8'h46, ovf=0.
//   W=8,SAT=0: a=8'h7F,b=8'h01 -> z=8'h80, ovf=1. Same with SAT=1 -> z=8'h7F, ovf=1.
//   SAT=1: a=8'h80,b=8'hFF -> z=8'h80, ovf=1; a=8'hF0,b=8'h05 -> z=8'hF5, ovf=0.
//   Ack withheld 5 cycles -> z and stb stable 5 cycles; ack -> stb low next edge.
//   Ack held high throughout -> stb high exactly 1 cycle.
//   stb held high -> captures repeat every LAT+3 cycles.
//   reset asserted 1 cycle in COMPUTE -> next cycle all outputs 0, state IDLE, no output_z_stb for that op.
//     Change a,b during COMPUTE -> result uses the captured values.

Source files
------------

// File: rtl/hs_int_add_responder.sv
// hs_int_add_responder: stb/ack responder that adds two W-bit operands after LAT cycles and holds the result until acked
module hs_int_add_responder #(
    parameter int W   = 8,
    parameter int LAT = 2,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] input_a,
    input  logic [W-1:0] input_b,
    input  logic         input_stb,
    output logic         input_ack,
    output logic [W-1:0] output_z,
    output logic         output_z_stb,
    input  logic         output_z_ack,
    output logic         overflow
);
    typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;
    state_t state, state_n;
    logic [W-1:0] a_r, b_r, a_n, b_n, z_n, s, z_c;
    logic [3:0] cnt, cnt_n;
    logic ack_n, stb_n, ovf_n, ovf_c;
    assign s     = a_r + b_r;
    assign ovf_c = (a_r[W-1] == b_r[W-1]) && (s[W-1] != a_r[W-1]);
    assign z_c   = (SAT && ovf_c) ? (a_r[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : s;
    // next-state and output decisions for the capture / compute / hold handshake
    always_comb begin
        state_n = state;
        a_n     = a_r;
        b_n     = b_r;
        cnt_n   = cnt;
        z_n     = output_z;
        ovf_n   = overflow;
        stb_n   = output_z_stb;
        ack_n   = 1'b0;
        case (state)
            IDLE: if (input_stb) begin
                a_n     = input_a;
                b_n     = input_b;
                ack_n   = 1'b1;
                cnt_n   = 4'(LAT);
                state_n = COMPUTE;
            end
            COMPUTE: if (cnt != 4'd0) cnt_n = cnt - 4'd1;
            else begin
                z_n     = z_c;
                ovf_n   = ovf_c;
                stb_n   = 1'b1;
                state_n = OUT;
            end
            OUT: if (output_z_ack) begin
                stb_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // state and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            a_r          <= '0;
            b_r          <= '0;
            cnt          <= '0;
            output_z     <= '0;
            overflow     <= 1'b0;
            output_z_stb <= 1'b0;
            input_ack    <= 1'b0;
        end else begin
            state        <= state_n;
            a_r          <= a_n;
            b_r          <= b_n;
            cnt          <= cnt_n;
            output_z     <= z_n;
            overflow     <= ovf_n;
            output_z_stb <= stb_n;
            input_ack    <= ack_n;
        end
    end
endmodule

// File: tb/tb_hs_int_add_responder.sv
// tb_hs_int_add_responder: directed scoreboard bench driving a wrapping and a saturating lane in lockstep
module tb_hs_int_add_responder;
    logic clk = 1'b0, reset = 1'b1;
    logic [7:0] input_a = '0, input_b = '0;
    logic input_stb = 1'b0, output_z_ack = 1'b0;
    logic ack0, ack1, stb0, stb1, ov0, ov1;
    logic [7:0] z0, z1;
    int checks = 0, failures = 0;
    logic [8:0] q0[$], q1[$];

    hs_int_add_responder #(.W(8), .LAT(2), .SAT(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .input_a(input_a), .input_b(input_b), .input_stb(input_stb),
        .input_ack(ack0), .output_z(z0), .output_z_stb(stb0), .output_z_ack(output_z_ack), .overflow(ov0));
    hs_int_add_responder #(.W(8), .LAT(2), .SAT(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .input_a(input_a), .input_b(input_b), .input_stb(input_stb),
        .input_ack(ack1), .output_z(z1), .output_z_stb(stb1), .output_z_ack(output_z_ack), .overflow(ov1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // wrap-lane monitor: pop on result rise, check hold stability afterwards
    logic p0 = 1'b0;
    logic [8:0] e0, h0;
    always @(negedge clk) begin
        if (stb0 && !p0) begin
            if (q0.size() == 0) chk("wrap_unexpected_result", 1, 0);
            else begin
                e0 = q0.pop_front();
                chk("wrap_z_ovf", {z0, ov0}, e0);
                h0 = {z0, ov0};
            end
        end else if (stb0 && p0) chk("wrap_hold", {z0, ov0}, h0);
        p0 = stb0;
    end

    // saturating-lane monitor
    logic p1 = 1'b0;
    logic [8:0] e1, h1;
    always @(negedge clk) begin
        if (stb1 && !p1) begin
            if (q1.size() == 0) chk("sat_unexpected_result", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk("sat_z_ovf", {z1, ov1}, e1);
                h1 = {z1, ov1};
            end
        end else if (stb1 && p1) chk("sat_hold", {z1, ov1}, h1);
        p1 = stb1;
    end

    task automatic wait_stb(output int n);
        n = 1;
        while (!stb0 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op(input logic [7:0] a, b, zw, zs, input logic ov, input int hold);
        int n;
        @(negedge clk);
        input_a = a; input_b = b; input_stb = 1'b1;
        q0.push_back({zw, ov}); q1.push_back({zs, ov});
        @(negedge clk);
        input_stb = 1'b0;
        chk("input_ack_pulse", {ack0, ack1}, 2'b11);
        input_a = ~a; input_b = 8'h55;
        @(negedge clk);
        chk("input_ack_drop", {ack0, ack1}, 2'b00);
        wait_stb(n);
        chk("result_latency", n, 3);
        chk("sat_stb_sync", stb1, stb0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("stb_held", {stb0, stb1}, 2'b11);
        end
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
        chk("stb_cleared", {stb0, stb1}, 2'b00);
    endtask

    initial begin
        int n, hi, last, acks;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {ack0, ack1, stb0, stb1, ov0, ov1, z0, z1}, 0);
        reset = 1'b0;
        op(8'h12, 8'h34, 8'h46, 8'h46, 1'b0, 0);
        op(8'h7F, 8'h01, 8'h80, 8'h7F, 1'b1, 0);
        op(8'h80, 8'hFF, 8'h7F, 8'h80, 1'b1, 5);
        op(8'hF0, 8'h05, 8'hF5, 8'hF5, 1'b0, 0);
        op(8'h80, 8'h80, 8'h00, 8'h80, 1'b1, 1);
        op(8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 0);
        op(8'h40, 8'h40, 8'h80, 8'h7F, 1'b1, 0);
        op(8'hC0, 8'hC0, 8'h80, 8'h80, 1'b0, 2);
        // ack held high throughout: result visible exactly one cycle
        output_z_ack = 1'b1;
        @(negedge clk);
        input_a = 8'h01; input_b = 8'h02; input_stb = 1'b1;
        q0.push_back({8'h03, 1'b0}); q1.push_back({8'h03, 1'b0});
        @(negedge clk);
        input_stb = 1'b0;
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (stb0) hi++;
        end
        chk("ack_held_stb_width", hi, 1);
        // stb and ack held high: captures repeat every LAT+3 cycles
        @(negedge clk);
        input_a = 8'h10; input_b = 8'h20; input_stb = 1'b1;
        repeat (3) begin
            q0.push_back({8'h30, 1'b0}); q1.push_back({8'h30, 1'b0});
        end
        acks = 0; last = 0; n = 0;
        while (acks < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (ack0) begin
                if (acks > 0) chk("b2b_period", n - last, 5);
                last = n;
                acks++;
                if (acks == 3) input_stb = 1'b0;
            end
        end
        chk("b2b_captures", acks, 3);
        repeat (6) @(negedge clk);
        output_z_ack = 1'b0;
        // reset during COMPUTE discards the operation
        @(negedge clk);
        input_a = 8'h11; input_b = 8'h22; input_stb = 1'b1;
        @(negedge clk);
        input_stb = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid_compute", {ack0, ack1, stb0, stb1, ov0, ov1, z0, z1}, 0);
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (stb0 || stb1) hi++;
        end
        chk("no_result_after_reset", hi, 0);
        op(8'h05, 8'h06, 8'h0B, 8'h0B, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
